change_dispense_ctrl: RTL
=========================

# change_dispense_ctrl

Sequencing controller for the vending machine's change-return path. It accepts a change amount in cents, drives the coin hopper one coin at a time (dollar, quarter or dime) over a req/ack handshake, and reports completion, coin counts and any undispensable remainder. It sits between the purchase FSM, which supplies the amount on purchase completion or cancel, and the hopper driver pins.

## Interface
- `CENT_W`, 12: width of the amount, remainder and coin counters.
- `TIMEOUT_CYC`, 1000: maximum cycles to wait in `REQ` or `REL` before aborting.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset; synchronous and active-low.
- `start` in 1: request to dispense `amount`; sampled only in `IDLE`.
- `amount` in `CENT_W`: change amount in cents.
- `disp_ack` in 1: hopper acknowledge (level).
- `disp_dollar`, `disp_quarter`, `disp_dime` out 1 each: one-hot coin request. At most one is high at any time.
- `busy` out 1: high in any state other than `IDLE`.
- `done` out 1: one-cycle pulse when the remainder reaches 0.
- `err` out 1: one-cycle pulse on an undispensable remainder or a timeout.
- `rem` out `CENT_W`: cents still owed.
- `n_dollar`, `n_quarter`, `n_dime` out `CENT_W` each: coins dispensed in the current job.

## Operation
- Reset (`rst_n`=0 at a rising edge):
  - FSM goes to `IDLE`.
  - All outputs become 0, including `rem` and all counts.
  - This applies mid-operation: any request drops on the next cycle and no `done`/`err` is issued.
- `IDLE`:
  - On `start`=1: `rem`←`amount`; all counts←0; timer←0; go to `SEL`.
  - `start` is ignored in every other state.
- `SEL`, coin-choice rule (in priority order):
  - dollar if `rem`≥100 and (`rem`−100)∉{5,15};
  - else quarter if `rem`≥25 and (`rem`−25)∉{5,15};
  - else dime if `rem`≥10 and (`rem`−10)∉{5,15}.
- `SEL`, transitions:
  - `rem`==0: pulse `done` and go to `IDLE`.
  - A coin is chosen: register the one-hot request, clear the timer, go to `REQ`.
  - No coin is choosable (`rem` in {5,15}, or `rem` not a multiple of 5): pulse `err`, go to `IDLE`, and leave `rem` holding the residue.
- `REQ`:
  - Hold the request.
  - On `disp_ack`=1: drop the request; `rem`−=coin value; increment that coin's counter; clear the timer; go to `REL`.
- `REL`:
  - Wait for `disp_ack`=0, then go to `SEL`.
  - A new request is never raised while `disp_ack` is high.
- Timeout: in `REQ` or `REL`, if the timer reaches `TIMEOUT_CYC`−1 without the awaited ack edge, then drop the request, pulse `err`, go to `IDLE`, and keep `rem` and the counts.
- Arithmetic: `rem` is unsigned `CENT_W`. Subtraction never underflows because a coin is chosen only when `rem` ≥ its value. Counters are not required to saturate, since a count cannot exceed `amount`/10.

## Timing
- All outputs are registered.
- Latency from `start` sampled at edge k:
  - the first request is high from edge k+1 (`SEL` is evaluated at edge k+1);
  - when `amount`=0, `done` is high for the cycle after edge k+1.
- Ack handling: `disp_ack` sampled high at edge m causes the request to be low and `rem` updated after edge m.
  - `disp_ack` sampled low at edge m+1 at the earliest causes `SEL` after edge m+1.
  - The next request is then high after edge m+2.
- Cost per coin with a 1-cycle ack pulse: 4 cycles (`REQ`, `REL`, `SEL`, plus the ack cycle).
- `done`/`err` are high exactly one cycle, coincident with `busy` falling. `done` and `err` are never high together.
- `start` arriving in the same cycle as `done`/`err` is ignored. A new job needs `start` while `busy`=0.

## Structure
- Shared package `vend_pkg`:
  - coin values `DOLLAR_CENTS`=100, `QUARTER_CENTS`=25, `DIME_CENTS`=10;
  - enum `coin_t` {`NONE`, `DOLLAR`, `QUARTER`, `DIME`};
  - FSM enum `disp_state_t` {`IDLE`, `SEL`, `REQ`, `REL`}.
- Sub-module `coin_select`: purely combinational. It maps `rem` to `coin_t` using the choice rule above and is instantiated once.
- Top level: FSM, timer, `rem`/counter registers, and request decode.

## Test plan
- `amount`=0 → `done` after 2 cycles; no request; all counts 0.
- `amount`=130, ack responder with 1-cycle delay → coins dollar, dime, dime, dime; counts 1/0/3; `done`; `rem`=0.
- `amount`=65 → quarter, then 4 dimes; counts 0/1/4; `done`.
- `amount`=15 → `err` 2 cycles after `start`; no request; `rem`=15. Repeat with `amount`=7 → `err`, `rem`=7.
- `TIMEOUT_CYC`=16, `amount`=100, ack held low → `disp_dollar` high for 16 cycles, then low; `err`; `rem`=100; `n_dollar`=0.
- `amount`=250 with `start` pulsed again mid-job → second `start` ignored. `rst_n`=0 after the first coin → all outputs 0 next cycle; no `done`.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared coin definitions and FSM state encoding for the change-return path.
package vend_pkg;

  localparam int DOLLAR_CENTS  = 100;
  localparam int QUARTER_CENTS = 25;
  localparam int DIME_CENTS    = 10;

  typedef enum logic [1:0] {NONE, DOLLAR, QUARTER, DIME} coin_t;

  typedef enum logic [1:0] {IDLE, SEL, REQ, REL} disp_state_t;

  // Request bits are ordered {dollar, quarter, dime}.
  function automatic logic [2:0] coin_onehot(input coin_t c);
    logic [2:0] oh;
    oh = 3'b000;
    case (c)
      DOLLAR:  oh = 3'b100;
      QUARTER: oh = 3'b010;
      DIME:    oh = 3'b001;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational coin choice: largest coin that does not strand a 5 or 15 cent residue.
module coin_select
  import vend_pkg::*;
#(
  parameter int CENT_W = 12
) (
  input  logic [CENT_W-1:0] rem,
  output coin_t             coin
);

  function automatic logic fits(input logic [CENT_W-1:0] r, input logic [CENT_W-1:0] v);
    logic [CENT_W-1:0] left;
    left = r - v;
    return (r >= v) && (left != CENT_W'(5)) && (left != CENT_W'(15));
  endfunction

  always_comb begin
    coin = NONE;
    if (fits(rem, CENT_W'(DOLLAR_CENTS)))
      coin = DOLLAR;
    else if (fits(rem, CENT_W'(QUARTER_CENTS)))
      coin = QUARTER;
    else if (fits(rem, CENT_W'(DIME_CENTS)))
      coin = DIME;
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change-return sequencer: drives the coin hopper one coin at a time over req/ack
// and reports done/err, remaining cents and per-coin counts.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last job's results
// SEL   | pick next coin, or finish with done/err
// REQ   | coin request held until the hopper acks
// REL   | waiting for the hopper to release ack
module change_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int CENT_W      = 12,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CENT_W-1:0] amount,
  input  logic              disp_ack,
  output logic              disp_dollar,
  output logic              disp_quarter,
  output logic              disp_dime,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CENT_W-1:0] rem,
  output logic [CENT_W-1:0] n_dollar,
  output logic [CENT_W-1:0] n_quarter,
  output logic [CENT_W-1:0] n_dime
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  disp_state_t       state_q, state_d;
  logic [2:0]        req_q, req_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CENT_W-1:0] rem_d, n_dollar_d, n_quarter_d, n_dime_d;
  logic [CENT_W-1:0] req_cents;
  logic              done_d, err_d, busy_d;
  coin_t             sel_coin;

  coin_select #(.CENT_W(CENT_W)) u_coin_select (
    .rem  (rem),
    .coin (sel_coin)
  );

  always_comb begin
    req_cents = '0;
    if (req_q[2])      req_cents = CENT_W'(DOLLAR_CENTS);
    else if (req_q[1]) req_cents = CENT_W'(QUARTER_CENTS);
    else if (req_q[0]) req_cents = CENT_W'(DIME_CENTS);
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    timer_d     = timer_q;
    rem_d       = rem;
    n_dollar_d  = n_dollar;
    n_quarter_d = n_quarter;
    n_dime_d    = n_dime;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d       = amount;
          n_dollar_d  = '0;
          n_quarter_d = '0;
          n_dime_d    = '0;
          timer_d     = TMR_LOAD;
          state_d     = SEL;
        end
      end
      SEL: begin
        if (rem == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (sel_coin == NONE) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          req_d   = coin_onehot(sel_coin);
          timer_d = TMR_LOAD;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack on the terminal cycle still wins over the timeout.
        if (disp_ack) begin
          req_d   = 3'b000;
          rem_d   = rem - req_cents;
          timer_d = TMR_LOAD;
          state_d = REL;
          if (req_q[2])      n_dollar_d  = n_dollar + 1'b1;
          else if (req_q[1]) n_quarter_d = n_quarter + 1'b1;
          else if (req_q[0]) n_dime_d    = n_dime + 1'b1;
        end else if (timer_q == '0) begin
          req_d   = 3'b000;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      REL: begin
        if (!disp_ack) begin
          state_d = SEL;
        end else if (timer_q == '0) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 3'b000;
      timer_q   <= '0;
      rem       <= '0;
      n_dollar  <= '0;
      n_quarter <= '0;
      n_dime    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      timer_q   <= timer_d;
      rem       <= rem_d;
      n_dollar  <= n_dollar_d;
      n_quarter <= n_quarter_d;
      n_dime    <= n_dime_d;
      done      <= done_d;
      err       <= err_d;
      busy      <= busy_d;
    end
  end

  assign disp_dollar  = req_q[2];
  assign disp_quarter = req_q[1];
  assign disp_dime    = req_q[0];

endmodule
